stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
// Single-clock controller for the multicycle LEGv8 datapath. It replaces the fixed-delay phase clocks.
// Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK by raising one stage enable per cycle.
// Stalls on a memory ready handshake, flags a memory timeout, and halts after a programmable instruction budget.
// Sits at datapath top level. Its enables gate the Fetch, Decode, Execute, Memory and Writeback blocks.
// PARAMETERS
// CNT_W        32  width of instr_count and cycle_count
// MAX_INSTR    30  instructions retired before HALT; 0 = unlimited
// MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before ERROR; 0 = never time out
// SKIP_MEM     1   1: non-memory instructions bypass MEMORY (EXECUTE->WRITEBACK)
// PORTS
// clk            in   1      system clock; all state changes on rising edge
// reset          in   1      synchronous, active-high reset
// run            in   1      level; 1 = start and keep issuing instructions
// mem_read       in   1      decoded control of the current instruction; sampled in EXECUTE
// mem_write      in   1      decoded control of the current instruction; sampled in EXECUTE
// mem_ready      in   1      data memory has completed the access
// fetch_en       out  1      instruction memory read and IR load
// decode_en      out  1      register file read
// execute_en     out  1      ALU and SREG update
// memory_en      out  1      data memory access and branch resolve; high in MEMORY and MEM_WAIT
// writeback_en   out  1      register file write
// pc_en          out  1      PC load (pc_src mux); high in WRITEBACK
// state          out  3      current state encoding (from package)
// busy           out  1      state is not IDLE, HALT or ERROR
// done           out  1      sticky; state == HALT
// err            out  1      sticky; state == ERROR
// instr_count    out  CNT_W  instructions retired (WRITEBACK completions)
// cycle_count    out  CNT_W  cycles spent outside IDLE, HALT and ERROR; saturates at all-ones
// BEHAVIOUR
// - Moore FSM with a registered state. All enables, busy, done and err are decoded from the state only.
// - Reset: state=IDLE; all outputs 0; counters 0. Reset wins over every other event, in any state.
// - Reset mid-instruction aborts the instruction. The next cycle is IDLE, with no WRITEBACK and no pc_en.
// - IDLE: run=1 -> FETCH, else stay.
// - FETCH -> DECODE -> EXECUTE, unconditional.
// - EXECUTE: if SKIP_MEM=1 and !(mem_read|mem_write), go to WRITEBACK; else go to MEMORY.
// - MEMORY: a non-memory op goes to WRITEBACK. A memory op with mem_ready=1 goes to WRITEBACK.
//   A memory op with mem_ready=0 goes to MEM_WAIT and clears the wait counter.
// - MEM_WAIT: mem_ready=1 -> WRITEBACK.
//   Else the wait counter increments; reaching MEM_TIMEOUT -> ERROR.
// - mem_read and mem_write are latched in EXECUTE and held for MEMORY/MEM_WAIT. Changes to the inputs after that are ignored.
// - WRITEBACK: instr_count += 1.
//   If MAX_INSTR!=0 and the new count == MAX_INSTR -> HALT.
//   Else if run=1 -> FETCH; else -> IDLE.
// - run is sampled only in IDLE and WRITEBACK. Dropping run mid-instruction lets the instruction complete.
// - HALT and ERROR are terminal until reset. run is ignored in both.
// - Latency: 4 cycles per non-memory op (SKIP_MEM=1), otherwise 5. Memory ops take 5 + wait cycles.
// - Enables are one-hot or all zero. Exactly one pc_en pulse per retired instruction.
// - Counters are unsigned CNT_W bits. instr_count wraps only if MAX_INSTR=0.
// STRUCTURE
// - Package seq_pkg holds the state typedef enum logic [2:0]:
//   IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, MEM_WAIT=5, WRITEBACK=6, HALT/ERROR via 7 plus the err flag.
//   It also holds the stage-enable bit positions.
// - Alternatively, widen the encoding to 4 bits if HALT and ERROR need distinct codes. This is the preferred option; state port width follows the package.
// - One sub-module, wait_timer: a counter with clear, enable and an expired output at MEM_TIMEOUT. MEM_TIMEOUT=0 disables expiry.
// TESTING
// 1. reset 2 cycles, run=1, mem_read=mem_write=0, SKIP_MEM=1
//    -> enables F,D,E,WB on cycles 1-4; pc_en on cycle 4; instr_count=1; next state FETCH.
// 2. mem_read=1, mem_ready low for 3 cycles after MEMORY
//    -> MEMORY, MEM_WAIT x3, WRITEBACK; instruction takes 8 cycles; memory_en high 4 cycles.
// 3. MEM_TIMEOUT=8, mem_write=1, mem_ready held 0
//    -> ERROR after 8 MEM_WAIT cycles; err=1, all enables 0; holds with run=1 until reset.
// 4. MAX_INSTR=3, run=1, no memory ops
//    -> HALT after 3rd WRITEBACK; done=1, instr_count=3, cycle_count=12; run toggling has no effect.
// 5. reset pulsed during EXECUTE
//    -> next cycle IDLE, counters 0, no writeback_en or pc_en; restarts at FETCH when run=1.
// 6. run dropped during DECODE
//    -> EXECUTE, WRITEBACK complete; instr_count+1; then IDLE, busy=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle LEGv8 stage sequencer.
//   state_t   : controller state encoding. HALT and ERROR have distinct codes,
//               so the state bus is 4 bits wide.
//   STATE_W   : width of the state bus presented on the top-level port.
//   EN_*      : bit positions of the stage enables inside the enable vector.
package seq_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXECUTE   = 4'd3,
    MEMORY    = 4'd4,
    MEM_WAIT  = 4'd5,
    WRITEBACK = 4'd6,
    HALT      = 4'd7,
    ERROR     = 4'd8
  } state_t;

  localparam int EN_FETCH     = 0;
  localparam int EN_DECODE    = 1;
  localparam int EN_EXECUTE   = 2;
  localparam int EN_MEMORY    = 3;
  localparam int EN_WRITEBACK = 4;
  localparam int EN_PC        = 5;
  localparam int EN_W         = 6;

  // Cycles in IDLE, HALT and ERROR are not instruction work.
  function automatic logic is_busy(input state_t s);
    return (s != IDLE) && (s != HALT) && (s != ERROR);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Consecutive memory-wait cycle counter.
//   i_clk     : clock
//   i_rst     : synchronous active-high reset
//   i_clr     : restart the count at zero (takes priority over i_en)
//   i_en      : count one more wait cycle
//   o_expired : the wait cycle in progress is the MEM_TIMEOUT-th one;
//               never asserted when MEM_TIMEOUT is 0
module wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  // r_cnt holds the number of wait cycles already completed, so the current
  // cycle is the last allowed one when r_cnt reaches MEM_TIMEOUT-1.
  assign o_expired = (MEM_TIMEOUT != 0) && (r_cnt == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle LEGv8 stage sequencer: steps one instruction at a time through
// FETCH, DECODE, EXECUTE, (MEMORY/MEM_WAIT) and WRITEBACK, raising one stage
// enable per cycle.
//   clk, reset            : clock, synchronous active-high reset
//   run                   : level, keep issuing instructions (sampled in IDLE/WRITEBACK)
//   mem_read, mem_write   : decoded memory controls, captured in EXECUTE
//   mem_ready             : data memory access complete
//   fetch_en .. pc_en     : stage enables decoded from the state
//   state                 : current state code (seq_pkg::state_t)
//   busy, done, err       : activity / halted / memory-timeout flags
//   instr_count           : retired instructions
//   cycle_count           : busy cycles, saturating
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MAX_INSTR   = 30,
  parameter int MEM_TIMEOUT = 16,
  parameter int SKIP_MEM    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               mem_ready,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               execute_en,
  output logic               memory_en,
  output logic               writeback_en,
  output logic               pc_en,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   instr_count,
  output logic [CNT_W-1:0]   cycle_count
);

  state_t            r_state;
  state_t            w_next;
  logic              r_mem_op;
  logic [CNT_W-1:0]  r_instr;
  logic [CNT_W-1:0]  r_cycle;
  logic [CNT_W-1:0]  w_instr_inc;
  logic              w_last_instr;
  logic              w_busy;
  logic              w_expired;
  logic [EN_W-1:0]   w_en;

  assign w_busy       = is_busy(r_state);
  assign w_instr_inc  = r_instr + CNT_W'(1);
  assign w_last_instr = (MAX_INSTR != 0) && (w_instr_inc == CNT_W'(MAX_INSTR));

  wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_clr     (r_state == MEMORY),
    .i_en      ((r_state == MEM_WAIT) && !mem_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (run) w_next = FETCH;
      FETCH:     w_next = DECODE;
      DECODE:    w_next = EXECUTE;
      // The live inputs decide the bypass; the latched copy is used afterwards.
      EXECUTE: begin
        if ((SKIP_MEM != 0) && !(mem_read || mem_write)) w_next = WRITEBACK;
        else                                             w_next = MEMORY;
      end
      MEMORY: begin
        if (!r_mem_op || mem_ready) w_next = WRITEBACK;
        else                        w_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_ready)      w_next = WRITEBACK;
        else if (w_expired) w_next = ERROR;
      end
      WRITEBACK: begin
        if (w_last_instr) w_next = HALT;
        else if (run)     w_next = FETCH;
        else              w_next = IDLE;
      end
      HALT:      w_next = HALT;
      ERROR:     w_next = ERROR;
      default:   w_next = IDLE;
    endcase
  end

  // Memory-op capture and the two counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_op <= 1'b0;
      r_instr  <= '0;
      r_cycle  <= '0;
    end else begin
      if (r_state == EXECUTE) r_mem_op <= mem_read | mem_write;
      if (r_state == WRITEBACK) r_instr <= w_instr_inc;
      if (w_busy && (r_cycle != '1)) r_cycle <= r_cycle + CNT_W'(1);
    end
  end

  always_comb begin
    w_en = '0;
    case (r_state)
      FETCH:     w_en[EN_FETCH]   = 1'b1;
      DECODE:    w_en[EN_DECODE]  = 1'b1;
      EXECUTE:   w_en[EN_EXECUTE] = 1'b1;
      MEMORY,
      MEM_WAIT:  w_en[EN_MEMORY]  = 1'b1;
      WRITEBACK: begin
        w_en[EN_WRITEBACK] = 1'b1;
        w_en[EN_PC]        = 1'b1;
      end
      default:   w_en = '0;
    endcase
  end

  assign fetch_en     = w_en[EN_FETCH];
  assign decode_en    = w_en[EN_DECODE];
  assign execute_en   = w_en[EN_EXECUTE];
  assign memory_en    = w_en[EN_MEMORY];
  assign writeback_en = w_en[EN_WRITEBACK];
  assign pc_en        = w_en[EN_PC];
  assign state        = r_state;
  assign busy         = w_busy;
  assign done         = (r_state == HALT);
  assign err          = (r_state == ERROR);
  assign instr_count  = r_instr;
  assign cycle_count  = r_cycle;

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic reset, run, mem_read, mem_write, mem_ready;

  logic a_f, a_d, a_e, a_m, a_w, a_pc, a_busy, a_done, a_err;
  logic [3:0]  a_state;
  logic [31:0] a_ic, a_cc;
  logic b_f, b_d, b_e, b_m, b_w, b_pc, b_busy, b_done, b_err;
  logic [3:0]  b_state;
  logic [7:0]  b_ic, b_cc;

  always #5 clk = ~clk;

  // A: bounded budget, timeout 8, memory bypass on.
  stage_sequencer #(.CNT_W(32), .MAX_INSTR(3), .MEM_TIMEOUT(8), .SKIP_MEM(1)) dut_a (
    .clk(clk), .reset(reset), .run(run), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready), .fetch_en(a_f), .decode_en(a_d), .execute_en(a_e),
    .memory_en(a_m), .writeback_en(a_w), .pc_en(a_pc), .state(a_state), .busy(a_busy),
    .done(a_done), .err(a_err), .instr_count(a_ic), .cycle_count(a_cc));

  // B: unlimited budget, no timeout, no bypass, narrow counters.
  stage_sequencer #(.CNT_W(8), .MAX_INSTR(0), .MEM_TIMEOUT(0), .SKIP_MEM(0)) dut_b (
    .clk(clk), .reset(reset), .run(run), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready), .fetch_en(b_f), .decode_en(b_d), .execute_en(b_e),
    .memory_en(b_m), .writeback_en(b_w), .pc_en(b_pc), .state(b_state), .busy(b_busy),
    .done(b_done), .err(b_err), .instr_count(b_ic), .cycle_count(b_cc));

  // Stage numbers: 0 idle, 1 fetch, 2 decode, 3 execute, 4 memory,
  // 5 memory wait, 6 writeback, 7 halt, 8 error.
  typedef struct {
    int     st;
    int     waits;
    bit     memop;
    longint ic;
    longint cc;
  } mdl_t;

  mdl_t ma, mb;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic mdl_t mstep(input mdl_t m, input int mi, input int mt, input bit sm,
                                 input bit r, input bit rd, input bit wr, input bit rdy,
                                 input bit rst);
    mdl_t n = m;
    if (rst) begin
      n.st = 0; n.waits = 0; n.memop = 0; n.ic = 0; n.cc = 0;
      return n;
    end
    if (m.st >= 1 && m.st <= 6) n.cc = m.cc + 1;
    case (m.st)
      0: if (r) n.st = 1;
      1: n.st = 2;
      2: n.st = 3;
      3: begin
        n.memop = rd | wr;
        n.st = (sm && !(rd | wr)) ? 6 : 4;
      end
      4: begin
        if (!m.memop || rdy) n.st = 6;
        else begin n.st = 5; n.waits = 0; end
      end
      5: begin
        if (rdy) n.st = 6;
        else begin
          n.waits = m.waits + 1;
          if (mt != 0 && n.waits == mt) n.st = 8;
        end
      end
      6: begin
        n.ic = m.ic + 1;
        if (mi != 0 && n.ic == mi) n.st = 7;
        else n.st = r ? 1 : 0;
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [3:0] st, input logic [8:0] fl,
                     input logic [31:0] ic, input logic [31:0] cc, input mdl_t m, input int w);
    longint mask;
    logic [8:0] ef;
    logic [31:0] eic, ecc;
    mask = (longint'(1) << w) - 1;
    ef = {m.st == 1, m.st == 2, m.st == 3, (m.st == 4 || m.st == 5), m.st == 6, m.st == 6,
          (m.st >= 1 && m.st <= 6), m.st == 7, m.st == 8};
    eic = 32'(m.ic & mask);
    ecc = 32'((m.cc > mask) ? mask : m.cc);
    n_cmp++;
    assert (st === 4'(m.st)) else begin
      n_bad++; $error("FAIL %s.state got %0d want %0d", tag, st, m.st);
    end
    n_cmp++;
    assert (fl === ef) else begin
      n_bad++; $error("FAIL %s.flags got %b want %b", tag, fl, ef);
    end
    n_cmp++;
    assert (ic === eic) else begin
      n_bad++; $error("FAIL %s.instr_count got %0d want %0d", tag, ic, eic);
    end
    n_cmp++;
    assert (cc === ecc) else begin
      n_bad++; $error("FAIL %s.cycle_count got %0d want %0d", tag, cc, ecc);
    end
  endtask

  task automatic dchk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++; $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit rd, input bit wr, input bit rdy, input bit rst);
    run = r; mem_read = rd; mem_write = wr; mem_ready = rdy; reset = rst;
    ma = mstep(ma, 3, 8, 1'b1, r, rd, wr, rdy, rst);
    mb = mstep(mb, 0, 0, 1'b0, r, rd, wr, rdy, rst);
    @(posedge clk);
    #1;
    chk("A", a_state, {a_f, a_d, a_e, a_m, a_w, a_pc, a_busy, a_done, a_err}, a_ic, a_cc, ma, 32);
    chk("B", b_state, {b_f, b_d, b_e, b_m, b_w, b_pc, b_busy, b_done, b_err},
        {24'd0, b_ic}, {24'd0, b_cc}, mb, 8);
  endtask

  initial begin
    int nm;
    bit rdv [8];
    bit rdyv[8];

    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    dchk("rst.state", 32'(a_state), 0);
    dchk("rst.outs", 32'({a_f, a_d, a_e, a_m, a_w, a_pc, a_busy, a_done, a_err}), 0);
    dchk("rst.ic", a_ic, 0);
    dchk("rst.cc", a_cc, 0);

    // Non-memory instruction: 4 cycles
    step(1, 0, 0, 0, 0); dchk("t1.fetch", 32'(a_f), 1);
    step(1, 0, 0, 0, 0); dchk("t1.decode", 32'(a_d), 1);
    step(1, 0, 0, 0, 0); dchk("t1.exec", 32'(a_e), 1);
    step(1, 0, 0, 0, 0); dchk("t1.wb_pc", 32'({a_w, a_pc, a_m}), 32'b110);
    step(1, 0, 0, 0, 0);
    dchk("t1.next", 32'(a_state), 1);
    dchk("t1.ic", a_ic, 1);
    dchk("t1.cc", a_cc, 4);

    // Load with three wait cycles; controls drop after EXECUTE
    step(0, 0, 0, 0, 1);
    rdv  = '{1, 1, 1, 1, 0, 0, 0, 0};
    rdyv = '{0, 0, 0, 0, 0, 0, 0, 1};
    nm = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, rdv[i], 0, rdyv[i], 0);
      nm += int'(a_m);
    end
    dchk("t2.mem_cycles", 32'(nm), 4);
    dchk("t2.wb", 32'(a_state), 6);
    step(1, 0, 0, 0, 0);
    dchk("t2.next", 32'(a_state), 1);
    dchk("t2.ic", a_ic, 1);

    // Store that never completes
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0);
    dchk("t3.last_wait", 32'(a_state), 5);
    step(1, 0, 1, 0, 0);
    dchk("t3.error", 32'(a_state), 8);
    dchk("t3.err", 32'(a_err), 1);
    dchk("t3.enables", 32'({a_f, a_d, a_e, a_m, a_w, a_pc}), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
    dchk("t3.hold", 32'(a_state), 8);

    // Instruction budget
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) step(1, 0, 0, 0, 0);
    dchk("t4.halt", 32'(a_state), 7);
    dchk("t4.done", 32'(a_done), 1);
    dchk("t4.ic", a_ic, 3);
    dchk("t4.cc", a_cc, 12);
    for (int i = 0; i < 4; i++) step(i[0], 0, 0, 0, 0);
    dchk("t4.hold", 32'(a_state), 7);
    dchk("t4.ic_hold", a_ic, 3);
    dchk("t4.cc_hold", a_cc, 12);

    // Reset during EXECUTE
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    dchk("t5.exec", 32'(a_state), 3);
    step(1, 0, 0, 0, 1);
    dchk("t5.idle", 32'(a_state), 0);
    dchk("t5.no_wb", 32'({a_w, a_pc}), 0);
    dchk("t5.ic", a_ic, 0);
    dchk("t5.cc", a_cc, 0);
    step(1, 0, 0, 0, 0);
    dchk("t5.restart", 32'(a_state), 1);

    // run dropped during DECODE
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); dchk("t6.exec", 32'(a_state), 3);
    step(0, 0, 0, 0, 0); dchk("t6.wb", 32'(a_state), 6);
    step(0, 0, 0, 0, 0);
    dchk("t6.idle", 32'(a_state), 0);
    dchk("t6.busy", 32'(a_busy), 0);
    dchk("t6.ic", a_ic, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      step(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
           ($urandom % 2) == 1, ($urandom_range(0, 99) < 3));

    // Long reset-free run: counter wrap and saturation on the narrow instance
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 2500; i++)
      step(($urandom % 16) != 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
           ($urandom % 5) < 3, 1'b0);
    dchk("b.cc_sat", {24'd0, b_cc}, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
